// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC3 memory responder.
// Defines the 16-bit word type, the per-port FSM state encoding, and the
// LFSR tap mask and step function used by the optional stall injector.
package lc3_mem_pkg;

  typedef logic [15:0] lc3_word_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_WAIT = 2'd1,
    P_DONE = 2'd2
  } port_state_e;

  // Counter width: covers the largest base latency (15) plus up to 3 stall cycles.
  localparam int CNT_W = 5;

  // Tap mask for x^4 + x^3 + 1 on a left-shifting register (bits 3 and 2).
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Handshake bundle between the LC3 pipeline (master) and the memory responder (slave).
// Carries the instruction fetch port (pc/instrmem_rd -> Instr_dout/complete_instr)
// and the data port (data_req/Data_addr/Data_rd/Data_din -> Data_dout/complete_data).
interface lc3_mem_if;
  import lc3_mem_pkg::*;

  logic      [15:0] pc;
  logic             instrmem_rd;
  lc3_word_t        Instr_dout;
  logic             complete_instr;

  logic             data_req;
  logic      [15:0] Data_addr;
  logic             Data_rd;
  lc3_word_t        Data_din;
  lc3_word_t        Data_dout;
  logic             complete_data;

  modport master (
    output pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );

endinterface

// File: rtl/lc3_mem_responder_port_fsm.sv
// One responder port: IDLE -> WAIT -> DONE sequencer with wait counter and request latches.
// Ports: clock/reset; req_i/addr_i/rd_i/din_i request; lat_i wait cycles sampled on accept;
// fire_* = array access happening on this edge (address/rd/din); complete_o registered pulse.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             req_i,
  input  logic [15:0]      addr_i,
  input  logic             rd_i,
  input  lc3_word_t        din_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             fire_o,
  output logic [15:0]      fire_addr_o,
  output logic             fire_rd_o,
  output lc3_word_t        fire_din_o,
  output logic             complete_o
);

  localparam logic [1:0] S_IDLE = P_IDLE;
  localparam logic [1:0] S_WAIT = P_WAIT;
  localparam logic [1:0] S_DONE = P_DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             rd_q, rd_d;
  lc3_word_t        din_q, din_d;
  logic             complete_q;
  logic             acc;

  // The edge that leaves DONE is also an accepting edge, so a request held
  // high is re-accepted there and back-to-back accesses are LAT+2 apart.
  assign acc = req_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (acc) begin
          addr_d  = addr_i;
          rd_d    = rd_i;
          din_d   = din_i;
          cnt_d   = lat_i;
          state_d = (lat_i == '0) ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array access happens on the edge that enters DONE. With zero latency that
  // is the accepting edge itself, so the access uses the live request fields.
  assign fire_o      = (acc && (lat_i == '0)) || ((state_q == S_WAIT) && (cnt_q == '0));
  assign fire_addr_o = acc ? addr_i : addr_q;
  assign fire_rd_o   = acc ? rd_i   : rd_q;
  assign fire_din_o  = acc ? din_i  : din_q;
  assign complete_o  = complete_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      din_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      din_q      <= din_d;
      complete_q <= fire_o;
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 memory responder: shared word array serving an instruction and a data port with fixed latency.
// Ports: clock, reset (async active-low), mem_if (slave side of lc3_mem_if), load_en/load_addr/load_data backdoor.
// Optional macro LC3_MEMRESP_STALL_INJECT_EN adds 0..3 pseudo-random wait cycles per access from a 4-bit LFSR.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 8,
  parameter int         INSTR_LAT  = 1,
  parameter int         DATA_LAT   = 2,
  parameter logic [3:0] LFSR_SEED  = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  lc3_mem_if.slave    mem_if,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  lc3_word_t   load_data
);

  localparam int AW    = DEPTH_LOG2;
  localparam int WORDS = 1 << DEPTH_LOG2;

  // An all-zero seed would freeze the LFSR.
  if (LFSR_SEED == 4'h0) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  lc3_word_t mem [0:WORDS-1];

  logic [CNT_W-1:0] instr_lat, data_lat;

`ifdef LC3_MEMRESP_STALL_INJECT_EN
  logic [3:0] lfsr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_step(lfsr_q);
  end

  // Extra wait cycles are taken from the LFSR value present at acceptance.
  assign instr_lat = CNT_W'(INSTR_LAT) + {3'b000, lfsr_q[1:0]};
  assign data_lat  = CNT_W'(DATA_LAT)  + {3'b000, lfsr_q[3:2]};
`else
  assign instr_lat = CNT_W'(INSTR_LAT);
  assign data_lat  = CNT_W'(DATA_LAT);
`endif

  logic        i_fire, d_fire;
  logic [15:0] i_addr, d_addr;
  logic        i_rd_unused, d_rd;
  lc3_word_t   i_din_unused, d_din;

  lc3_mem_port_fsm u_instr_port (
    .clock       (clock),
    .reset       (reset),
    .req_i       (mem_if.instrmem_rd),
    .addr_i      (mem_if.pc),
    .rd_i        (1'b1),
    .din_i       (16'h0000),
    .lat_i       (instr_lat),
    .fire_o      (i_fire),
    .fire_addr_o (i_addr),
    .fire_rd_o   (i_rd_unused),
    .fire_din_o  (i_din_unused),
    .complete_o  (mem_if.complete_instr)
  );

  lc3_mem_port_fsm u_data_port (
    .clock       (clock),
    .reset       (reset),
    .req_i       (mem_if.data_req),
    .addr_i      (mem_if.Data_addr),
    .rd_i        (mem_if.Data_rd),
    .din_i       (mem_if.Data_din),
    .lat_i       (data_lat),
    .fire_o      (d_fire),
    .fire_addr_o (d_addr),
    .fire_rd_o   (d_rd),
    .fire_din_o  (d_din),
    .complete_o  (mem_if.complete_data)
  );

  // Upper address bits alias; only the low AW bits index the array.
  logic [AW-1:0] i_idx, d_idx, l_idx;
  assign i_idx = i_addr[AW-1:0];
  assign d_idx = d_addr[AW-1:0];
  assign l_idx = load_addr[AW-1:0];

  logic unused_bits;
  assign unused_bits = ^{i_rd_unused, i_din_unused, i_addr, d_addr, load_addr};

  // Array has no reset. The data write is gated by reset so a write pending at
  // reset assertion is dropped. The preload is placed last so it wins a
  // same-word collision with a data write on the same edge.
  always_ff @(posedge clock) begin
    if (d_fire && !d_rd && reset) begin
      mem[d_idx] <= d_din;
    end
    if (load_en) begin
      mem[l_idx] <= load_data;
    end
  end

  // Read data is captured from the pre-edge array contents, which gives the
  // instruction port read-before-write against a same-edge data write.
  lc3_word_t instr_dout_q, data_dout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_dout_q <= '0;
      data_dout_q  <= '0;
    end else begin
      if (i_fire) begin
        instr_dout_q <= mem[i_idx];
      end
      if (d_fire && d_rd) begin
        data_dout_q <= mem[d_idx];
      end
    end
  end

  assign mem_if.Instr_dout = instr_dout_q;
  assign mem_if.Data_dout  = data_dout_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: latency, write/read, collisions, aliasing, reset abort, back-to-back.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  localparam int INSTR_LAT = 1;
  localparam int DATA_LAT  = 2;
`ifdef LC3_MEMRESP_STALL_INJECT_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  lc3_word_t   load_data = '0;

  lc3_mem_if m ();

  lc3_mem_responder #(
    .DEPTH_LOG2 (8),
    .INSTR_LAT  (INSTR_LAT),
    .DATA_LAT   (DATA_LAT),
    .LFSR_SEED  (4'hA)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_if    (m),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clock = ~clock;

  // Edge counter and reference LFSR history (value present before each edge).
  int         cyc = 0;
  logic [3:0] ref_lfsr;
  logic [3:0] hist [0:4095];

  always @(posedge clock or negedge reset) begin
    if (!reset) ref_lfsr <= 4'hA;
    else        ref_lfsr <= {ref_lfsr[2:0], ref_lfsr[3] ^ ref_lfsr[2]};
  end

  always @(posedge clock) begin
    if (cyc < 4096) hist[cyc] <= ref_lfsr;
    cyc <= cyc + 1;
  end

  function automatic int xi(input int a);
    return STALL ? int'(hist[a][1:0]) : 0;
  endfunction

  function automatic int xd(input int a);
    return STALL ? int'(hist[a][3:2]) : 0;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input lc3_word_t d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // k = edges after the accepting edge until complete is first seen.
  task automatic fetch(input logic [15:0] a, output lc3_word_t d, output int k, output int acc);
    @(negedge clock);
    m.pc = a; m.instrmem_rd = 1'b1; acc = cyc;
    @(negedge clock);
    m.instrmem_rd = 1'b0; k = 0;
    while (!m.complete_instr && k < 64) begin
      @(negedge clock); k++;
    end
    d = m.Instr_dout;
  endtask

  task automatic data_acc(input logic rd, input logic [15:0] a, input lc3_word_t din,
                          output lc3_word_t d, output int k, output int acc);
    @(negedge clock);
    m.data_req = 1'b1; m.Data_rd = rd; m.Data_addr = a; m.Data_din = din; acc = cyc;
    @(negedge clock);
    m.data_req = 1'b0; k = 0;
    while (!m.complete_data && k < 64) begin
      @(negedge clock); k++;
    end
    d = m.Data_dout;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    lc3_word_t d;
    int k, acc, ed, e, guard;
    logic seen;

    m.pc = '0; m.instrmem_rd = 1'b0; m.data_req = 1'b0;
    m.Data_addr = '0; m.Data_rd = 1'b0; m.Data_din = '0;

    repeat (2) @(negedge clock);
    check("rst_instr_dout", 32'(m.Instr_dout), 32'h0);
    check("rst_data_dout",  32'(m.Data_dout),  32'h0);
    check("rst_cpl_instr",  32'(m.complete_instr), 32'h0);
    check("rst_cpl_data",   32'(m.complete_data),  32'h0);
    @(negedge clock);
    reset = 1'b1;

    load(16'h3000, 16'h1234);
    load(16'h0020, 16'hC0DE);
    load(16'h0005, 16'h0001);
    load(16'h0009, 16'h0000);

    // Fetch latency and pulse width.
    fetch(16'h3000, d, k, acc);
    check("fetch_lat",  32'(k), 32'(INSTR_LAT + 1 + xi(acc)));
    check("fetch_data", 32'(d), 32'h1234);
    @(negedge clock);
    check("fetch_pulse", 32'(m.complete_instr), 32'h0);

    // Data read, then write leaves Data_dout alone, then read back.
    data_acc(1'b1, 16'h0020, 16'h0, d, k, acc);
    check("dread_lat",  32'(k), 32'(DATA_LAT + 1 + xd(acc)));
    check("dread_data", 32'(d), 32'hC0DE);
    data_acc(1'b0, 16'h0010, 16'hBEEF, d, k, acc);
    check("dwrite_lat",  32'(k), 32'(DATA_LAT + 1 + xd(acc)));
    check("dwrite_hold", 32'(d), 32'hC0DE);
    @(negedge clock);
    check("dwrite_pulse", 32'(m.complete_data), 32'h0);
    data_acc(1'b1, 16'h0010, 16'h0, d, k, acc);
    check("wr_rd_back", 32'(d), 32'hBEEF);

`ifndef LC3_MEMRESP_STALL_INJECT_EN
    // Data write and instruction read reach DONE on the same edge.
    @(negedge clock);
    m.data_req = 1'b1; m.Data_rd = 1'b0; m.Data_addr = 16'h0005; m.Data_din = 16'h5555;
    @(negedge clock);
    m.data_req = 1'b0; m.pc = 16'h0005; m.instrmem_rd = 1'b1;
    @(negedge clock);
    m.instrmem_rd = 1'b0;
    repeat (2) @(negedge clock);
    check("coll_cpl_instr", 32'(m.complete_instr), 32'h1);
    check("coll_cpl_data",  32'(m.complete_data),  32'h1);
    check("coll_old_word",  32'(m.Instr_dout),     32'h0001);
    fetch(16'h0005, d, k, acc);
    check("coll_new_word", 32'(d), 32'h5555);
`endif

    // Address aliasing above DEPTH_LOG2 bits.
    data_acc(1'b0, 16'h0105, 16'hAAAA, d, k, acc);
    data_acc(1'b1, 16'h0005, 16'h0, d, k, acc);
    check("wrap_data", 32'(d), 32'hAAAA);
    fetch(16'h0205, d, k, acc);
    check("wrap_instr", 32'(d), 32'hAAAA);

    // Preload collides with a data write on the edge entering DONE.
    @(negedge clock);
    m.data_req = 1'b1; m.Data_rd = 1'b0; m.Data_addr = 16'h0030; m.Data_din = 16'h1111; acc = cyc;
    @(negedge clock);
    m.data_req = 1'b0;
    ed = acc + DATA_LAT + 1 + xd(acc);
    guard = 0;
    while (cyc != ed && guard < 64) begin
      @(negedge clock); guard++;
    end
    load_en = 1'b1; load_addr = 16'h0030; load_data = 16'h2222;
    @(negedge clock);
    load_en = 1'b0;
    check("ldcoll_cpl", 32'(m.complete_data), 32'h1);
    data_acc(1'b1, 16'h0030, 16'h0, d, k, acc);
    check("ldcoll_wins", 32'(d), 32'h2222);

    // Reset during WAIT of a write aborts it.
    @(negedge clock);
    m.data_req = 1'b1; m.Data_rd = 1'b0; m.Data_addr = 16'h0009; m.Data_din = 16'h7777;
    @(negedge clock);
    m.data_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rstmid_instr_dout", 32'(m.Instr_dout), 32'h0);
    check("rstmid_data_dout",  32'(m.Data_dout),  32'h0);
    check("rstmid_cpl_instr",  32'(m.complete_instr), 32'h0);
    seen = m.complete_data;
    repeat (4) begin
      @(negedge clock);
      seen = seen | m.complete_data;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      seen = seen | m.complete_data;
    end
    check("rstmid_no_cpl", 32'(seen), 32'h0);
    data_acc(1'b1, 16'h0009, 16'h0, d, k, acc);
    check("rstmid_dropped", 32'(d), 32'h0000);

    // Back-to-back fetches with the request held high.
    @(negedge clock);
    m.pc = 16'h3000; m.instrmem_rd = 1'b1; acc = cyc;
    for (int i = 0; i < 16; i++) begin
      guard = 0;
      do begin
        @(negedge clock); guard++;
      end while (!m.complete_instr && guard < 64);
      e = cyc - 1;
      if (i == 15) m.instrmem_rd = 1'b0;
      check($sformatf("b2b_lat%0d", i), 32'(e - acc), 32'(INSTR_LAT + 1 + xi(acc)));
      acc = e + 1;
    end
    check("b2b_data", 32'(m.Instr_dout), 32'h1234);
    repeat (6) @(negedge clock);
    check("b2b_idle", 32'(m.complete_instr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
